// File: rtl/hs32_bus_matrix.sv
// HS32 bus matrix: round-robin arbitration of NM masters onto one shared bus,
// address decode to NS MMIO slaves or the default SRAM port, with an ack timeout.
module hs32_bus_matrix #(
    parameter int NM = 2,
    parameter int NS = 6,
    parameter int MASK_LEN = 8,
    parameter logic [NS*MASK_LEN-1:0] BASE = '0,
    parameter logic [NS*MASK_LEN-1:0] MASK = '0,
    parameter logic [31-MASK_LEN:0] MMIO_PAGE = 24'h000001,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NM-1:0]     m_stb,
    input  logic [NM-1:0]     m_rw,
    input  logic [NM*32-1:0]  m_addr,
    input  logic [NM*32-1:0]  m_dtw,
    output logic [NM-1:0]     m_ack,
    output logic [NM-1:0]     m_err,
    output logic [31:0]       m_dtr,
    output logic [NS-1:0]     s_stb,
    input  logic [NS-1:0]     s_ack,
    input  logic [NS*32-1:0]  s_dtr,
    output logic              d_stb,
    input  logic              d_ack,
    input  logic [31:0]       d_dtr,
    output logic              b_rw,
    output logic [31:0]       b_addr,
    output logic [31:0]       b_dtw,
    output logic [NM-1:0]     grant
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int TW = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_last;
    logic [NS-1:0] s_sel;
    logic          d_sel;
    logic          err;
    logic [TW-1:0] wcnt;

    logic          req_any;
    logic [IW-1:0] req_idx;
    logic [31:0]   req_addr;
    logic [NS-1:0] dec_sel;
    logic          dec_dflt;
    logic          dec_miss;
    logic          tgt_ack;
    logic [31:0]   tgt_dtr;
    logic [NM-1:0] gidx_oh;

    // Round-robin search starts just after the last master that got a bus transfer.
    always_comb begin
        int cand;
        cand    = 0;
        req_any = 1'b0;
        req_idx = '0;
        for (int i = 1; i <= NM; i++) begin
            cand = int'(rr_last) + i;
            if (cand >= NM) begin
                cand = cand - NM;
            end
            if (!req_any && m_stb[cand]) begin
                req_any = 1'b1;
                req_idx = IW'(cand);
            end
        end
    end

    // Descending scan so the lowest-index matching slave wins overlapping windows.
    always_comb begin
        req_addr = m_addr[int'(req_idx)*32 +: 32];
        dec_sel  = '0;
        dec_dflt = 1'b0;
        dec_miss = 1'b0;
        if (req_addr[31:MASK_LEN] != MMIO_PAGE) begin
            dec_dflt = 1'b1;
        end else begin
            for (int k = NS - 1; k >= 0; k--) begin
                if ((req_addr[MASK_LEN-1:0] & MASK[k*MASK_LEN +: MASK_LEN])
                        == BASE[k*MASK_LEN +: MASK_LEN]) begin
                    dec_sel = NS'(1) << k;
                end
            end
            dec_miss = (dec_sel == '0);
        end
    end

    always_comb begin
        tgt_ack = d_sel & d_ack;
        tgt_dtr = d_dtr;
        for (int k = 0; k < NS; k++) begin
            if (s_sel[k]) begin
                tgt_ack = s_ack[k];
                tgt_dtr = s_dtr[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gidx    <= '0;
            rr_last <= IW'(NM - 1);
            s_sel   <= '0;
            d_sel   <= 1'b0;
            err     <= 1'b0;
            wcnt    <= '0;
            m_dtr   <= '0;
            b_rw    <= 1'b0;
            b_addr  <= '0;
            b_dtw   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gidx   <= req_idx;
                        b_rw   <= m_rw[req_idx];
                        b_addr <= req_addr;
                        b_dtw  <= m_dtw[int'(req_idx)*32 +: 32];
                        s_sel  <= dec_sel;
                        d_sel  <= dec_dflt;
                        wcnt   <= '0;
                        if (dec_miss) begin
                            err   <= 1'b1;
                            m_dtr <= '0;
                            state <= RESP;
                        end else begin
                            err     <= 1'b0;
                            rr_last <= req_idx;
                            state   <= XFER;
                        end
                    end
                end
                XFER: begin
                    wcnt <= wcnt + 1'b1;
                    // An ack arriving on the final allowed cycle beats the timeout.
                    if (tgt_ack) begin
                        m_dtr <= tgt_dtr;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        m_dtr <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign gidx_oh = NM'(1) << gidx;
    assign grant   = (state != IDLE) ? gidx_oh : '0;
    assign m_ack   = (state == RESP) ? gidx_oh : '0;
    assign m_err   = (state == RESP && err) ? gidx_oh : '0;
    assign s_stb   = (state == XFER) ? s_sel : '0;
    assign d_stb   = (state == XFER) && d_sel;

endmodule

// File: tb/tb_hs32_bus_matrix.sv
// Bench for hs32_bus_matrix: directed scenarios plus randomized rounds checked
// against a transaction-level model of arbitration, decode and timeout.
module tb_hs32_bus_matrix;

    localparam int NM = 2;
    localparam int NS = 6;
    localparam int TO = 4;
    localparam logic [47:0] BASE_P = {8'h10, 8'h10, 8'h0C, 8'h08, 8'h04, 8'h00};
    localparam logic [47:0] MASK_P = {8'hF0, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC};

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0] m_stb, m_rw, m_ack, m_err, grant;
    logic [NM*32-1:0] m_addr, m_dtw;
    logic [31:0] m_dtr, d_dtr, b_addr, b_dtw;
    logic [NS-1:0] s_stb;
    logic [NS-1:0] s_ack = '0;
    logic [NS*32-1:0] s_dtr;
    logic d_stb, b_rw;
    logic d_ack = 1'b0;

    always #5 clk = ~clk;

    hs32_bus_matrix #(
        .NM(NM), .NS(NS), .MASK_LEN(8), .BASE(BASE_P), .MASK(MASK_P),
        .MMIO_PAGE(24'h000001), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_stb(m_stb), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw),
        .m_ack(m_ack), .m_err(m_err), .m_dtr(m_dtr),
        .s_stb(s_stb), .s_ack(s_ack), .s_dtr(s_dtr),
        .d_stb(d_stb), .d_ack(d_ack), .d_dtr(d_dtr),
        .b_rw(b_rw), .b_addr(b_addr), .b_dtw(b_dtw), .grant(grant)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] sval[NS];
    logic [31:0] dval;
    logic [31:0] rq_addr[NM];
    logic [31:0] rq_dtw[NM];
    logic        rq_rw[NM];
    int          rq_w[NM];
    bit          noise = 1'b0;
    int          scnt = 0;

    int o_n, o_stray, o_multi;
    int o_m[2], o_ack[2], o_lat[2];
    int o_stb[2][7];
    logic o_err[2], o_rw[2];
    logic [31:0] o_dtr[2], o_addr[2], o_dtw[2];

    // Slave responder: acks the active strobe after rq_w wait cycles of the granted master
    // (negative = never); with noise set, every non-strobed slave acks as well.
    always @(posedge clk) begin
        int w;
        bit hit;
        #1;
        if (s_stb != '0 || d_stb) scnt = scnt + 1;
        else scnt = 0;
        w = grant[1] ? rq_w[1] : rq_w[0];
        hit = (w >= 0) && (scnt == w + 1);
        s_ack = (hit ? s_stb : '0) | (noise ? ~s_stb : '0);
        d_ack = (hit & d_stb) | (noise & ~d_stb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int k = 0; k < NS; k++) s_dtr[k*32 +: 32] = sval[k];
        d_dtr = dval;
    endtask

    // Target index: 0..5 slave, 6 default port, 7 unmapped.
    function automatic int model_target(logic [31:0] a);
        int off;
        if (a[31:8] != 24'h000001) return 6;
        off = int'(a[7:0]);
        if (off < 20) return off / 4;
        if (off < 32) return 5;
        return 7;
    endfunction

    function automatic int stb_total(int j);
        int s = 0;
        for (int i = 0; i < 7; i++) s += o_stb[j][i];
        return s;
    endfunction

    // Raises the masked requests and records what each completed transfer looked like.
    task automatic run_round(input logic [NM-1:0] req);
        int t, lat;
        o_n = 0; o_stray = 0; o_multi = 0; lat = 0; t = 0;
        for (int j = 0; j < 2; j++) begin
            o_m[j] = -1; o_ack[j] = -1; o_lat[j] = -1; o_err[j] = 1'bx; o_dtr[j] = 'x;
            for (int s = 0; s < 7; s++) o_stb[j][s] = 0;
        end
        for (int m = 0; m < NM; m++) begin
            m_addr[m*32 +: 32] = rq_addr[m];
            m_dtw[m*32 +: 32]  = rq_dtw[m];
            m_rw[m]            = rq_rw[m];
        end
        m_stb = req;
        while ((m_stb != '0 || grant != '0) && t < 60) begin
            tick();
            t++;
            if (grant == '0) begin
                if (s_stb != '0 || d_stb) o_stray++;
            end else begin
                lat++;
                if (o_n < 2) begin
                    for (int s = 0; s < NS; s++) if (s_stb[s]) o_stb[o_n][s]++;
                    if (d_stb) o_stb[o_n][6]++;
                end
            end
            if (m_ack != '0) begin
                if ($countones(m_ack) != 1 || m_ack != grant) o_multi++;
                if (o_n < 2) begin
                    o_m[o_n] = m_ack[1] ? 1 : 0;
                    o_ack[o_n] = t; o_lat[o_n] = lat;
                    o_err[o_n] = |(m_err & m_ack); o_dtr[o_n] = m_dtr;
                    o_addr[o_n] = b_addr; o_rw[o_n] = b_rw; o_dtw[o_n] = b_dtw;
                end
                o_n++;
                lat = 0;
                m_stb = m_stb & ~m_ack;
            end else if (m_err != '0) begin
                o_multi++;
            end
        end
        if (t >= 60) begin
            m_stb = '0; rst = 1'b1; tick(); rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m_stb = '0; m_rw = '0; m_addr = '0; m_dtw = '0;
        tick(); tick();
        tests++; if (grant !== '0 || m_ack !== '0 || m_err !== '0) begin fails++;
            $display("[TB] FAIL reset_handshake: grant=%b ack=%b err=%b want 0", grant, m_ack, m_err); end
        tests++; if (s_stb !== '0 || d_stb !== 1'b0) begin fails++;
            $display("[TB] FAIL reset_strobes: s_stb=%b d_stb=%b want 0", s_stb, d_stb); end
        tests++; if (m_dtr !== 32'h0 || b_addr !== 32'h0 || b_dtw !== 32'h0 || b_rw !== 1'b0) begin fails++;
            $display("[TB] FAIL reset_regs: dtr=%h addr=%h dtw=%h rw=%b want 0", m_dtr, b_addr, b_dtw, b_rw); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        for (int k = 0; k < NS; k++) sval[k] = $urandom;
        sval[1] = 32'hCAFE0001;
        dval = $urandom | 32'h1;
        load_data();
        rq_addr[0] = 32'h0000_0104; rq_rw[0] = 1'b0; rq_dtw[0] = 32'h0; rq_w[0] = 0;
        run_round(2'b01);
        tests++; if (o_m[0] !== 0 || o_ack[0] !== 2) begin fails++;
            $display("[TB] FAIL basic_latency: master=%0d cycle=%0d want 0/2", o_m[0], o_ack[0]); end
        tests++; if (o_dtr[0] !== 32'hCAFE0001 || o_err[0] !== 1'b0) begin fails++;
            $display("[TB] FAIL basic_data: dtr=%h err=%b want cafe0001/0", o_dtr[0], o_err[0]); end
        tests++; if (o_stb[0][1] !== 1 || stb_total(0) !== 1 || o_stray !== 0) begin fails++;
            $display("[TB] FAIL basic_strobe: s1=%0d total=%0d stray=%0d want 1/1/0", o_stb[0][1], stb_total(0), o_stray); end
    endtask

    task automatic test_round_robin();
        rq_addr[0] = 32'h0000_0100; rq_rw[0] = 1'b0; rq_w[0] = 0;
        rq_addr[1] = 32'h0000_0108; rq_rw[1] = 1'b1; rq_w[1] = 1; rq_dtw[1] = $urandom;
        run_round(2'b11);
        tests++; if (o_n !== 2 || o_m[0] !== 1 || o_m[1] !== 0) begin fails++;
            $display("[TB] FAIL rr_after_m0: n=%0d order=%0d,%0d want 2 1,0", o_n, o_m[0], o_m[1]); end
        run_round(2'b10);
        run_round(2'b11);
        tests++; if (o_n !== 2 || o_m[0] !== 0 || o_m[1] !== 1) begin fails++;
            $display("[TB] FAIL rr_after_m1: n=%0d order=%0d,%0d want 2 0,1", o_n, o_m[0], o_m[1]); end
        tests++; if (o_multi !== 0 || o_lat[1] !== 3) begin fails++;
            $display("[TB] FAIL rr_handshake: multi=%0d lat=%0d want 0/3", o_multi, o_lat[1]); end
    endtask

    task automatic test_default_write();
        rq_addr[1] = 32'h2000_0000; rq_rw[1] = 1'b1; rq_dtw[1] = 32'h0000_1234; rq_w[1] = 3;
        run_round(2'b10);
        tests++; if (o_stb[0][6] !== 4 || stb_total(0) !== 4) begin fails++;
            $display("[TB] FAIL dflt_strobe: d=%0d total=%0d want 4/4", o_stb[0][6], stb_total(0)); end
        tests++; if (o_dtw[0] !== 32'h1234 || o_rw[0] !== 1'b1 || o_addr[0] !== 32'h2000_0000) begin fails++;
            $display("[TB] FAIL dflt_bus: dtw=%h rw=%b addr=%h want 1234/1/20000000", o_dtw[0], o_rw[0], o_addr[0]); end
        tests++; if (o_m[0] !== 1 || o_lat[0] !== 5 || o_err[0] !== 1'b0 || o_dtr[0] !== dval) begin fails++;
            $display("[TB] FAIL dflt_ack: m=%0d lat=%0d err=%b dtr=%h want 1/5/0/%h", o_m[0], o_lat[0], o_err[0], o_dtr[0], dval); end
    endtask

    task automatic test_unmapped();
        rq_addr[0] = 32'h0000_01F0; rq_rw[0] = 1'b0; rq_w[0] = 0;
        run_round(2'b01);
        tests++; if (o_ack[0] !== 1 || o_err[0] !== 1'b1) begin fails++;
            $display("[TB] FAIL unmapped_ack: cycle=%0d err=%b want 1/1", o_ack[0], o_err[0]); end
        tests++; if (stb_total(0) !== 0 || o_dtr[0] !== 32'h0) begin fails++;
            $display("[TB] FAIL unmapped_side: strobes=%0d dtr=%h want 0/0", stb_total(0), o_dtr[0]); end
    endtask

    task automatic test_timeout();
        noise = 1'b1;
        rq_addr[0] = 32'h0000_0108; rq_rw[0] = 1'b0; rq_w[0] = -1;
        run_round(2'b01);
        noise = 1'b0;
        tests++; if (o_stb[0][2] !== TO || stb_total(0) !== TO) begin fails++;
            $display("[TB] FAIL timeout_strobe: s2=%0d total=%0d want %0d", o_stb[0][2], stb_total(0), TO); end
        tests++; if (o_err[0] !== 1'b1 || o_lat[0] !== TO + 1 || o_dtr[0] !== 32'h0) begin fails++;
            $display("[TB] FAIL timeout_err: err=%b lat=%0d dtr=%h want 1/%0d/0", o_err[0], o_lat[0], o_dtr[0], TO + 1); end
        rq_w[0] = TO - 1;
        run_round(2'b01);
        tests++; if (o_err[0] !== 1'b0 || o_dtr[0] !== sval[2] || o_lat[0] !== TO + 1) begin fails++;
            $display("[TB] FAIL timeout_lastack: err=%b dtr=%h lat=%0d want 0/%h/%0d", o_err[0], o_dtr[0], o_lat[0], sval[2], TO + 1); end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        rq_addr[0] = 32'h0000_0100; rq_w[0] = 0;
        run_round(2'b01);
        rq_addr[0] = 32'h0000_010C; rq_w[0] = -1;
        m_addr[31:0] = rq_addr[0]; m_rw[0] = 1'b0; m_stb = 2'b01;
        tick(); tick();
        tests++; if (s_stb !== 6'b001000) begin fails++;
            $display("[TB] FAIL midrst_pre: s_stb=%b want 001000", s_stb); end
        rst = 1'b1; m_stb = '0;
        tick();
        tests++; if (s_stb !== '0 || d_stb !== 1'b0 || grant !== '0 || m_ack !== '0) begin fails++;
            $display("[TB] FAIL midrst_abort: s_stb=%b d=%b grant=%b ack=%b want 0", s_stb, d_stb, grant, m_ack); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); if (m_ack != '0) acks++; end
        tests++; if (acks !== 0) begin fails++;
            $display("[TB] FAIL midrst_noack: acks=%0d want 0", acks); end
        rq_addr[0] = 32'h0000_0100; rq_w[0] = 0;
        rq_addr[1] = 32'h0000_0104; rq_w[1] = 0;
        run_round(2'b11);
        tests++; if (o_m[0] !== 0 || o_n !== 2) begin fails++;
            $display("[TB] FAIL midrst_prio: first=%0d n=%0d want 0/2", o_m[0], o_n); end
    endtask

    task automatic test_random();
        logic [NM-1:0] req, pend;
        logic [31:0] a, edtr;
        logic eerr;
        int rr, pick, tg, sc, nexp, bad;
        rst = 1'b1; m_stb = '0; tick(); rst = 1'b0;
        rr = NM - 1;
        for (int r = 0; r < 60; r++) begin
            req = NM'($urandom_range(1, 3));
            noise = 1'($urandom_range(0, 1));
            for (int m = 0; m < NM; m++) begin
                case ($urandom_range(0, 2))
                    0: begin a = $urandom; if (a[31:8] == 24'h000001) a[31] = 1'b1; end
                    1: a = {24'h000001, 8'($urandom_range(0, 31))};
                    default: a = {24'h000001, 8'($urandom_range(32, 255))};
                endcase
                rq_addr[m] = a; rq_rw[m] = 1'($urandom_range(0, 1));
                rq_dtw[m] = $urandom; rq_w[m] = int'($urandom_range(0, 6)) - 1;
            end
            run_round(req);
            nexp = $countones(req);
            tests++; if (o_n !== nexp || o_stray !== 0 || o_multi !== 0) begin fails++;
                $display("[TB] FAIL rnd%0d_round: n=%0d stray=%0d multi=%0d want %0d/0/0", r, o_n, o_stray, o_multi, nexp); end
            pend = req;
            for (int j = 0; j < nexp && j < 2; j++) begin
                pick = 0;
                for (int i = NM; i >= 1; i--) if (pend[(rr + i) % NM]) pick = (rr + i) % NM;
                pend[pick] = 1'b0;
                tg = model_target(rq_addr[pick]);
                if (tg != 7) rr = pick;
                sc = (tg == 7) ? 0 : ((rq_w[pick] < 0 || rq_w[pick] >= TO) ? TO : rq_w[pick] + 1);
                eerr = (tg == 7) || (rq_w[pick] < 0 || rq_w[pick] >= TO);
                edtr = eerr ? 32'h0 : ((tg == 6) ? dval : sval[tg]);
                tests++; if (o_m[j] !== pick || o_err[j] !== eerr || o_dtr[j] !== edtr) begin fails++;
                    $display("[TB] FAIL rnd%0d_xfer%0d: m=%0d err=%b dtr=%h want %0d/%b/%h", r, j, o_m[j], o_err[j], o_dtr[j], pick, eerr, edtr); end
                tests++; if (o_lat[j] !== sc + 1) begin fails++;
                    $display("[TB] FAIL rnd%0d_lat%0d: got %0d want %0d", r, j, o_lat[j], sc + 1); end
                tests++; if (o_addr[j] !== rq_addr[pick] || o_rw[j] !== rq_rw[pick] || o_dtw[j] !== rq_dtw[pick]) begin fails++;
                    $display("[TB] FAIL rnd%0d_bus%0d: addr=%h rw=%b dtw=%h want %h/%b/%h", r, j, o_addr[j], o_rw[j], o_dtw[j], rq_addr[pick], rq_rw[pick], rq_dtw[pick]); end
                bad = 0;
                for (int s = 0; s < 7; s++) if (o_stb[j][s] != ((s == tg) ? sc : 0)) bad++;
                tests++; if (bad !== 0) begin fails++;
                    $display("[TB] FAIL rnd%0d_stb%0d: %0d strobe lines wrong, target %0d want %0d cycles", r, j, bad, tg, sc); end
            end
        end
        noise = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < NM; m++) begin rq_w[m] = 0; rq_addr[m] = '0; rq_dtw[m] = '0; rq_rw[m] = 1'b0; end
        for (int k = 0; k < NS; k++) sval[k] = '0;
        dval = '0;
        load_data();
        test_reset();
        test_basic_read();
        test_round_robin();
        test_default_write();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
